// File: rtl/axil_reg_slave_if.sv
// ============================================================================
// Module      : axil_reg_slave_if
// Description : AXI4-Lite channel bundle with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axil_reg_slave_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

`default_nettype wire

// File: rtl/axil_reg_slave.sv
// ============================================================================
// Module      : axil_reg_slave
// Description : AXI4-Lite register bank with byte strobes, SLVERR decode and
//               configurable read latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_reg_slave #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_REGS   = 16,
    parameter int RD_LATENCY = 0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    axil_reg_slave_if.slave s_axil
);
    localparam int          c_IDX_W    = ADDR_WIDTH - 2;
    localparam int          c_SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [31:0] c_NUM_REGS = 32'(NUM_REGS);
    localparam logic [2:0]  c_LAT_LAST = 3'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);
    localparam logic [1:0]  c_OKAY     = 2'b00;
    localparam logic [1:0]  c_SLVERR   = 2'b10;

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    // ---------------- write path ----------------
    logic                  r_aw_full, r_w_full, r_awready, r_wready, r_bvalid;
    logic [c_IDX_W-1:0]    r_aw_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic [1:0]            r_bresp;
    logic                  w_aw_hs, w_w_hs, w_commit, w_aw_full_nxt, w_w_full_nxt;
    logic                  w_aw_in_range;
    logic [c_SEL_W-1:0]    w_aw_sel;

    assign w_aw_hs       = s_axil.awvalid & r_awready;
    assign w_w_hs        = s_axil.wvalid & r_wready;
    assign w_commit      = r_aw_full & r_w_full & (~r_bvalid | s_axil.bready);
    assign w_aw_full_nxt = ~w_commit & (r_aw_full | w_aw_hs);
    assign w_w_full_nxt  = ~w_commit & (r_w_full | w_w_hs);
    assign w_aw_in_range = (32'(r_aw_idx) < c_NUM_REGS);
    assign w_aw_sel      = r_aw_idx[c_SEL_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_OKAY;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_regs    <= '{default: '0};
        end else begin
            // Readies are registered copies of "buffer will be empty".
            r_aw_full <= w_aw_full_nxt;
            r_w_full  <= w_w_full_nxt;
            r_awready <= ~w_aw_full_nxt;
            r_wready  <= ~w_w_full_nxt;
            if (w_aw_hs) r_aw_idx <= s_axil.awaddr[ADDR_WIDTH-1:2];
            if (w_w_hs) begin
                r_wdata <= s_axil.wdata;
                r_wstrb <= s_axil.wstrb;
            end
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_aw_in_range ? c_OKAY : c_SLVERR;
                if (w_aw_in_range) begin
                    for (int i = 0; i < STRB_WIDTH; i++) begin
                        if (r_wstrb[i]) r_regs[w_aw_sel][8*i +: 8] <= r_wdata[8*i +: 8];
                    end
                end
            end else if (s_axil.bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // ---------------- read path ----------------
    rd_state_t             r_state, w_state_nxt;
    logic [2:0]            r_cnt;
    logic                  r_arready;
    logic [c_IDX_W-1:0]    r_ar_idx;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic                  w_ar_hs, w_capture, w_rd_in_range;
    logic [c_IDX_W-1:0]    w_rd_idx;
    logic [c_SEL_W-1:0]    w_rd_sel;

    assign w_ar_hs = s_axil.arvalid & r_arready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RD_IDLE: if (w_ar_hs) w_state_nxt = (RD_LATENCY > 0) ? RD_WAIT : RD_RESP;
            RD_WAIT: if (r_cnt == c_LAT_LAST) w_state_nxt = RD_RESP;
            RD_RESP: if (s_axil.rready) w_state_nxt = RD_IDLE;
            default: w_state_nxt = RD_IDLE;
        endcase
    end

    // A zero-latency read captures in the AR handshake cycle, before the index is latched.
    assign w_rd_idx      = (r_state == RD_IDLE) ? s_axil.araddr[ADDR_WIDTH-1:2] : r_ar_idx;
    assign w_rd_sel      = w_rd_idx[c_SEL_W-1:0];
    assign w_rd_in_range = (32'(w_rd_idx) < c_NUM_REGS);
    assign w_capture     = (w_state_nxt == RD_RESP) && (r_state != RD_RESP);

    always_ff @(posedge clk) begin
        if (rst) r_state <= RD_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 3'd0;
            r_arready <= 1'b0;
            r_ar_idx  <= '0;
            r_rdata   <= '0;
            r_rresp   <= c_OKAY;
        end else begin
            r_arready <= (w_state_nxt == RD_IDLE);
            if (w_ar_hs) r_ar_idx <= s_axil.araddr[ADDR_WIDTH-1:2];
            r_cnt <= (r_state == RD_WAIT) ? r_cnt + 3'd1 : 3'd0;
            if (w_capture) begin
                r_rdata <= w_rd_in_range ? r_regs[w_rd_sel] : '0;
                r_rresp <= w_rd_in_range ? c_OKAY : c_SLVERR;
            end
        end
    end

    logic w_unused_bits;
    assign w_unused_bits = ^{s_axil.awprot, s_axil.arprot,
                             s_axil.awaddr[1:0], s_axil.araddr[1:0]};

    assign s_axil.awready = r_awready;
    assign s_axil.wready  = r_wready;
    assign s_axil.bvalid  = r_bvalid;
    assign s_axil.bresp   = r_bresp;
    assign s_axil.arready = r_arready;
    assign s_axil.rvalid  = (r_state == RD_RESP);
    assign s_axil.rdata   = r_rdata;
    assign s_axil.rresp   = r_rresp;
endmodule

`default_nettype wire

// File: tb/tb_axil_reg_slave.sv
// ============================================================================
// Module      : tb_axil_reg_slave
// Description : Two DUT configurations (256 regs/latency 0, 16 regs/latency 3)
//               driven through a shared, selectable stimulus port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_reg_slave;
    logic clk = 1'b0;
    logic rst;
    logic sel;
    always #5 clk = ~clk;

    logic [11:0] awaddr, araddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    axil_reg_slave_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) if_a ();
    axil_reg_slave_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) if_b ();

    assign if_a.awaddr = awaddr;  assign if_b.awaddr = awaddr;
    assign if_a.awprot = 3'b0;    assign if_b.awprot = 3'b0;
    assign if_a.wdata  = wdata;   assign if_b.wdata  = wdata;
    assign if_a.wstrb  = wstrb;   assign if_b.wstrb  = wstrb;
    assign if_a.araddr = araddr;  assign if_b.araddr = araddr;
    assign if_a.arprot = 3'b0;    assign if_b.arprot = 3'b0;
    assign if_a.awvalid = awvalid & ~sel;  assign if_b.awvalid = awvalid & sel;
    assign if_a.wvalid  = wvalid  & ~sel;  assign if_b.wvalid  = wvalid  & sel;
    assign if_a.bready  = bready  & ~sel;  assign if_b.bready  = bready  & sel;
    assign if_a.arvalid = arvalid & ~sel;  assign if_b.arvalid = arvalid & sel;
    assign if_a.rready  = rready  & ~sel;  assign if_b.rready  = rready  & sel;

    assign awready = sel ? if_b.awready : if_a.awready;
    assign wready  = sel ? if_b.wready  : if_a.wready;
    assign bvalid  = sel ? if_b.bvalid  : if_a.bvalid;
    assign bresp   = sel ? if_b.bresp   : if_a.bresp;
    assign arready = sel ? if_b.arready : if_a.arready;
    assign rvalid  = sel ? if_b.rvalid  : if_a.rvalid;
    assign rdata   = sel ? if_b.rdata   : if_a.rdata;
    assign rresp   = sel ? if_b.rresp   : if_a.rresp;

    axil_reg_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .STRB_WIDTH(4),
                     .NUM_REGS(256), .RD_LATENCY(0)) dut_a (.clk(clk), .rst(rst), .s_axil(if_a));
    axil_reg_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .STRB_WIDTH(4),
                     .NUM_REGS(16), .RD_LATENCY(3)) dut_b (.clk(clk), .rst(rst), .s_axil(if_b));

    // Reference: plain register arrays plus each DUT's size and latency.
    logic [31:0] ref_mem [2][256];
    int          nregs [2] = '{256, 16};
    int          rdlat [2] = '{0, 3};
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_write(input logic [11:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        int idx = int'(a[11:2]);
        if (idx >= nregs[sel]) return 2'b10;
        for (int i = 0; i < 4; i++) if (s[i]) ref_mem[sel][idx][8*i +: 8] = d[8*i +: 8];
        return 2'b00;
    endfunction

    function automatic logic [33:0] model_read(input logic [11:0] a);
        int idx = int'(a[11:2]);
        if (idx >= nregs[sel]) return {2'b10, 32'h0};
        return {2'b00, ref_mem[sel][idx]};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) for (int i = 0; i < 256; i++) ref_mem[k][i] = 32'h0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input logic v);
        sel = v;
        #1;
    endtask

    // Presents AW and W after independent delays; returns in the cycle after the last handshake.
    task automatic send(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int awd, input int wd);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int c = 0;
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && c < 40) begin
            awvalid = !aw_done && (c >= awd);
            wvalid  = !w_done && (c >= wd);
            if (aw_done) check("aw_held_low", awready, 0);
            if (w_done)  check("w_held_low", wready, 0);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            cyc();
            c++;
            aw_done |= hs_aw;
            w_done  |= hs_w;
        end
        awvalid = 0; wvalid = 0;
        check("aw_accepted", aw_done, 1);
        check("w_accepted", w_done, 1);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int awd, input int wd);
        logic [1:0] e;
        bready = 1;
        send(a, d, s, awd, wd);
        e = model_write(a, d, s);
        check("b_early", bvalid, 0);
        cyc();
        check("b_valid", bvalid, 1);
        check("b_resp", bresp, e);
        check("aw_ready_back", awready, 1);
        check("w_ready_back", wready, 1);
        cyc();
        check("b_single", bvalid, 0);
    endtask

    task automatic rd(input logic [11:0] a, input int stall);
        logic [33:0] e;
        int c = 0;
        e = model_read(a);
        araddr = a; arvalid = 1;
        while (!arready && c < 20) begin cyc(); c++; end
        check("ar_ready", arready, 1);
        cyc();
        arvalid = 0;
        for (int k = 0; k < rdlat[sel]; k++) begin
            check("r_early", rvalid, 0);
            check("ar_busy", arready, 0);
            cyc();
        end
        check("r_valid", rvalid, 1);
        check("ar_busy_resp", arready, 0);
        check("r_data", rdata, e[31:0]);
        check("r_resp", rresp, e[33:32]);
        for (int k = 0; k < stall; k++) begin
            cyc();
            check("r_hold_valid", rvalid, 1);
            check("r_hold_data", rdata, e[31:0]);
        end
        rready = 1;
        cyc();
        rready = 0;
        check("r_done", rvalid, 0);
        check("ar_ready_back", arready, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  e1, e2;
        logic [11:0] a;
        int          c;
        rst = 1; sel = 0;
        awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        model_clear();

        cyc(); cyc();
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        rst = 0;
        cyc();
        check("post_rst_awready", awready, 1);
        check("post_rst_wready", wready, 1);
        check("post_rst_arready", arready, 1);

        // 256-register instance, zero read latency
        wr(12'h200, 32'h11223344, 4'hF, 0, 0);
        rd(12'h200, 0);
        wr(12'h304, 32'hFFFFFFFF, 4'hF, 0, 0);
        wr(12'h304, 32'h55667788, 4'h3, 0, 0);
        rd(12'h304, 1);
        check("partial_strobe_model", ref_mem[0][193], 32'hFFFF7788);
        wr(12'h010, 32'hA0000001, 4'hF, 3, 0);
        wr(12'h014, 32'hA0000002, 4'hF, 0, 0);
        wr(12'h018, 32'hA0000003, 4'hF, 0, 5);
        rd(12'h010, 0); rd(12'h014, 0); rd(12'h018, 0);
        wr(12'hFFC, 32'hDEADBEEF, 4'hF, 0, 0);
        rd(12'hFFC, 0);

        // 16-register instance, read latency 3
        set_sel(1);
        wr(12'h03C, 32'h0BADF00D, 4'hF, 0, 0);
        wr(12'h040, 32'hA5A5A5A5, 4'hF, 0, 0);
        rd(12'h040, 0);
        rd(12'h03C, 4);
        rd(12'h000, 0);

        // Second write issued while the first B beat is stalled.
        bready = 0;
        send(12'h008, 32'hCAFE0001, 4'hF, 0, 0);
        e1 = model_write(12'h008, 32'hCAFE0001, 4'hF);
        cyc();
        check("bp_b1_valid", bvalid, 1);
        check("bp_b1_resp", bresp, e1);
        send(12'h00C, 32'hCAFE0002, 4'hF, 0, 0);
        cyc();
        check("bp_awready_full", awready, 0);
        check("bp_wready_full", wready, 0);
        check("bp_b1_still", bvalid, 1);
        rd(12'h00C, 0);
        bready = 1;
        cyc();
        e2 = model_write(12'h00C, 32'hCAFE0002, 4'hF);
        check("bp_b2_valid", bvalid, 1);
        check("bp_b2_resp", bresp, e2);
        cyc();
        check("bp_b2_done", bvalid, 0);
        rd(12'h00C, 0);
        rd(12'h008, 0);

        // Randomized traffic on both instances against the array model
        for (int k = 0; k < 2; k++) begin
            set_sel(k[0]);
            for (int n = 0; n < 30; n++) begin
                a = 12'(($urandom_range(0, (k == 0) ? 299 : 19) * 4) + $urandom_range(0, 3));
                if ($urandom_range(0, 1) == 0)
                    wr(a, $urandom, 4'($urandom_range(0, 15)),
                       $urandom_range(0, 3), $urandom_range(0, 3));
                else
                    rd(a, $urandom_range(0, 2));
            end
        end

        // Reset with a read response pending and the AW buffer full
        set_sel(1);
        wr(12'h020, 32'h12345678, 4'hF, 0, 0);
        araddr = 12'h020; arvalid = 1;
        cyc();
        arvalid = 0;
        awaddr = 12'h024; awvalid = 1;
        cyc();
        awvalid = 0;
        c = 0;
        while (!rvalid && c < 10) begin cyc(); c++; end
        check("mid_rvalid", rvalid, 1);
        check("mid_aw_full", awready, 0);
        rst = 1;
        cyc();
        rst = 0;
        model_clear();
        check("mr_awready", awready, 0);
        check("mr_wready", wready, 0);
        check("mr_arready", arready, 0);
        check("mr_bvalid", bvalid, 0);
        check("mr_rvalid", rvalid, 0);
        check("mr_bresp", bresp, 0);
        check("mr_rresp", rresp, 0);
        check("mr_rdata", rdata, 0);
        cyc();
        check("mr_awready_back", awready, 1);
        check("mr_wready_back", wready, 1);
        check("mr_arready_back", arready, 1);
        check("mr_no_b_beat", bvalid, 0);
        check("mr_no_r_beat", rvalid, 0);
        rd(12'h020, 0);
        wr(12'h004, 32'h00000077, 4'hF, 2, 0);
        rd(12'h004, 0);
        set_sel(0);
        rd(12'h200, 0);
        rd(12'h304, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
